// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a param_mux selector through 0..SIGNAL_COUNT-1 on a start
// pulse, snapshots each mux output word and offers it downstream on valid/ready.
//
// Handshake: data_o/last_o are offered while valid_o=1 and are held stable,
// together with sel_o, until an edge where valid_o && ready_i; that edge is the
// transfer. ready_i has no effect while valid_o=0.
//
// SIGNAL_COUNT must be >= 1 and <= 2**SELECTOR_WIDTH.
module mux_scan_ctrl #(
    parameter int INPUT_WIDTH    = 32,
    parameter int SELECTOR_WIDTH = 2,
    parameter int SIGNAL_COUNT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [INPUT_WIDTH-1:0]    mux_data_i,
    output logic [SELECTOR_WIDTH-1:0] sel_o,
    output logic [INPUT_WIDTH-1:0]    data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_SEND   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [SELECTOR_WIDTH-1:0] LAST_IDX = SELECTOR_WIDTH'(SIGNAL_COUNT - 1);

    state_t                    state_q, state_d;
    logic [SELECTOR_WIDTH-1:0] idx_q,   idx_d;
    logic [INPUT_WIDTH-1:0]    data_q,  data_d;
    logic                      valid_q, valid_d;
    logic                      last_q,  last_d;

    // State register: async reset aborts any burst with no partial output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Next-state: SELECT is the mux settle cycle and captures at its closing edge;
    // SEND holds everything until the transfer, then advances or finishes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start_i) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                data_d  = mux_data_i;
                valid_d = 1'b1;
                last_d  = (idx_q == LAST_IDX);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        // Wrap here so unused selector codes are never driven.
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SELECT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only; nothing passes through
    // combinationally from the inputs.
    always_comb begin
        sel_o   = '0;
        if ((state_q == S_SELECT) || (state_q == S_SEND)) begin
            sel_o = idx_q;
        end
        data_o  = data_q;
        valid_o = valid_q;
        last_o  = last_q;
        busy_o  = (state_q != S_IDLE);
        done_o  = (state_q == S_DONE);
        state_o = state_q;
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a 4-input instance (a) for directed sequences and
// a 3-input instance (b) for randomised backpressure with a scoreboard.
module tb_mux_scan_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- instance a: SIGNAL_COUNT=4 ----------------
    logic        start_a, ready_a;
    logic [31:0] in_a [4];
    logic [31:0] mux_a, data_a;
    logic [1:0]  sel_a, state_a;
    logic        valid_a, last_a, busy_a, done_a;

    assign mux_a = in_a[sel_a];

    mux_scan_ctrl #(.INPUT_WIDTH(32), .SELECTOR_WIDTH(2), .SIGNAL_COUNT(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .mux_data_i(mux_a),
        .sel_o(sel_a), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a),
        .last_o(last_a), .busy_o(busy_a), .done_o(done_a), .state_o(state_a)
    );

    // ---------------- instance b: SIGNAL_COUNT=3 ----------------
    logic        start_b, ready_b;
    logic [31:0] in_b [4];
    logic [31:0] mux_b, data_b;
    logic [1:0]  sel_b, state_b;
    logic        valid_b, last_b, busy_b, done_b;

    assign mux_b = in_b[sel_b];

    mux_scan_ctrl #(.INPUT_WIDTH(32), .SELECTOR_WIDTH(2), .SIGNAL_COUNT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .mux_data_i(mux_b),
        .sel_o(sel_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
        .last_o(last_b), .busy_o(busy_b), .done_o(done_b), .state_o(state_b)
    );

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int hs_a         = 0;
    int sel_b_bad    = 0;
    int pos_b        = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_word;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; checks and drives happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count transfers on instance a.
    always @(posedge clk) begin
        if (!rst && valid_a && ready_a) hs_a++;
    end

    // Scoreboard for instance b: every transfer must match the next queued word.
    always @(posedge clk) begin
        if (!rst && sel_b == 2'd3) sel_b_bad++;
        if (!rst && valid_b && ready_b) begin
            if (exp_q.size() == 0) begin
                check("b_underflow", 32'd1, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                check("b_data", data_b, exp_word);
                check("b_last", {31'd0, last_b}, {31'd0, (pos_b == 2)});
                check("b_sel", {30'd0, sel_b}, pos_b);
                pos_b = (pos_b == 2) ? 0 : pos_b + 1;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table for the basic burst ----------------
    typedef struct {
        logic [1:0]  sel;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vec [10];

    task automatic check_a_idle(input string tag);
        check({tag, "_sel"},   {30'd0, sel_a}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
        check({tag, "_data"},  data_a, 32'd0);
        check({tag, "_last"},  {31'd0, last_a}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_a}, 32'd0);
        check({tag, "_done"},  {31'd0, done_a}, 32'd0);
        check({tag, "_state"}, {30'd0, state_a}, 32'd0);
    endtask

    task automatic wait_done_a(input string tag);
        bit seen;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (done_a) seen = 1;
            tick();
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int base;
        bit got_done;

        // Row i describes the cycle i+1 after the start cycle.
        //            sel   valid data          last  busy  done
        vec[0] = '{2'd0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0};
        vec[1] = '{2'd0, 1'b1, 32'hA0,      1'b0, 1'b1, 1'b0};
        vec[2] = '{2'd1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0};
        vec[3] = '{2'd1, 1'b1, 32'hB1,      1'b0, 1'b1, 1'b0};
        vec[4] = '{2'd2, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0};
        vec[5] = '{2'd2, 1'b1, 32'hC2,      1'b0, 1'b1, 1'b0};
        vec[6] = '{2'd3, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0};
        vec[7] = '{2'd3, 1'b1, 32'hD3,      1'b1, 1'b1, 1'b0};
        vec[8] = '{2'd0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1};
        vec[9] = '{2'd0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0};

        rst     = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b1;
        start_b = 1'b0;
        ready_b = 1'b0;
        in_a[0] = 32'hA0; in_a[1] = 32'hB1; in_a[2] = 32'hC2; in_a[3] = 32'hD3;
        in_b[0] = 32'h0;  in_b[1] = 32'h0;  in_b[2] = 32'h0;  in_b[3] = 32'hDEADBEEF;

        // 1: reset values
        tick();
        tick();
        check_a_idle("t1_reset");
        rst = 1'b0;
        tick();

        // 2: basic burst with ready held high
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_sel[%0d]", i),   {30'd0, sel_a},   {30'd0, vec[i].sel});
            check($sformatf("t2_valid[%0d]", i), {31'd0, valid_a}, {31'd0, vec[i].valid});
            if (vec[i].valid)
                check($sformatf("t2_data[%0d]", i), data_a, vec[i].data);
            check($sformatf("t2_last[%0d]", i),  {31'd0, last_a},  {31'd0, vec[i].last});
            check($sformatf("t2_busy[%0d]", i),  {31'd0, busy_a},  {31'd0, vec[i].busy});
            check($sformatf("t2_done[%0d]", i),  {31'd0, done_a},  {31'd0, vec[i].done});
            tick();
        end

        // 3: backpressure on word 2, with the mux input changing during the stall
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        ready_a = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) begin
            check($sformatf("t3_valid[%0d]", s), {31'd0, valid_a}, 32'd1);
            check($sformatf("t3_data[%0d]", s),  data_a, 32'hC2);
            check($sformatf("t3_sel[%0d]", s),   {30'd0, sel_a}, 32'd2);
            check($sformatf("t3_last[%0d]", s),  {31'd0, last_a}, 32'd0);
            if (s == 1) in_a[2] = 32'hEE;
            if (s == 4) ready_a = 1'b1;
            tick();
        end
        check("t3_after_valid", {31'd0, valid_a}, 32'd0);
        check("t3_after_sel", {30'd0, sel_a}, 32'd3);
        tick();
        check("t3_w3_data", data_a, 32'hD3);
        check("t3_w3_last", {31'd0, last_a}, 32'd1);
        tick();
        check("t3_done", {31'd0, done_a}, 32'd1);
        tick();
        in_a[2] = 32'hC2;

        // 4a: start pulses while busy are ignored
        base = hs_a;
        start_a = 1'b1;
        tick();
        for (int c = 1; c < 12; c++) begin
            start_a = (c == 3 || c == 6 || c == 9);
            if (c == 9) check("t4a_done", {31'd0, done_a}, 32'd1);
            tick();
        end
        start_a = 1'b0;
        check("t4a_busy_after", {31'd0, busy_a}, 32'd0);
        check("t4a_words", hs_a - base, 32'd4);

        // 4b: start held high restarts right after done
        base = hs_a;
        start_a = 1'b1;
        tick();
        repeat (8) tick();
        check("t4b_done", {31'd0, done_a}, 32'd1);
        tick();
        check("t4b_idle_busy", {31'd0, busy_a}, 32'd0);
        tick();
        check("t4b_restart_busy", {31'd0, busy_a}, 32'd1);
        check("t4b_restart_state", {30'd0, state_a}, 32'd1);
        check("t4b_restart_sel", {30'd0, sel_a}, 32'd0);
        start_a = 1'b0;
        wait_done_a("t4b");
        check("t4b_words", hs_a - base, 32'd8);

        // 5: async reset mid-burst after the first transfer
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        check("t5_pre_data", data_a, 32'hB1);
        #2 rst = 1'b1;
        #1;
        check_a_idle("t5_reset");
        tick();
        rst = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("t5_first_valid", {31'd0, valid_a}, 32'd1);
        check("t5_first_data", data_a, 32'hA0);
        check("t5_first_sel", {30'd0, sel_a}, 32'd0);
        wait_done_a("t5");

        // 6: three-input instance, random ready, scoreboard
        pos_b = 0;
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < 3; k++) begin
                in_b[k] = $urandom;
                exp_q.push_back(in_b[k]);
            end
            start_b = 1'b1;
            ready_b = 1'($urandom_range(0, 1));
            tick();
            start_b = 1'b0;
            got_done = 0;
            for (int c = 0; c < 200 && !got_done; c++) begin
                ready_b = 1'($urandom_range(0, 1));
                if (done_b) got_done = 1;
                tick();
            end
            check("t6_burst_done", {31'd0, got_done}, 32'd1);
            if (!got_done) break;
        end
        ready_b = 1'b0;
        tick();
        check("t6_queue_empty", exp_q.size(), 32'd0);
        check("t6_sel_range", sel_b_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
